// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and register-address constants for the hazard controller
package pipe_ctrl_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load sitting in EX
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  idex_memread_i,
    input  logic [REG_ADDR_W-1:0] idex_rt_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs_i,
    input  logic [REG_ADDR_W-1:0] ifid_rt_i,
    input  logic                  ifid_uses_rt_i,
    output logic                  loaduse_o
);
    assign loaduse_o = idex_memread_i && (idex_rt_i != ZERO_REG) &&
                       ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hold/flush/bubble/freeze sequencer for load-use, ID branches and data-memory waits
// Optional saturating stall/flush performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic             err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e              r_state, w_next;
    logic [WAIT_W-1:0]   r_wait, w_wait_inc, w_wait_nxt;
    logic                r_err;
    logic                w_loaduse, w_memstall, w_in_err, w_timeout;

    load_use_detect u_load_use_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .loaduse_o      (w_loaduse)
    );

    assign w_memstall = mem_req_i & ~mem_ready_i;
    assign w_in_err   = (r_state == ERR);
    // counter value after this cycle's wait; ERR once it reaches the timeout
    assign w_wait_inc = (r_state == RUN) ? WAIT_W'(1) : r_wait + 1'b1;
    assign w_timeout  = (w_wait_inc == WAIT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_wait  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
            r_err   <= r_err | (w_next == ERR);
        end
    end

    always_comb begin
        w_next        = w_in_err ? ERR : w_memstall ? (w_timeout ? ERR : MEM_WAIT) : RUN;
        w_wait_nxt    = w_in_err ? r_wait : w_memstall ? w_wait_inc : '0;
        pc_write_o    = 1'b1;
        ifid_hold_o   = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        freeze_o      = 1'b0;
        if (rst_i) begin
            pc_write_o   = 1'b0;
            ifid_flush_o = 1'b1;
        end else if (w_in_err || w_memstall) begin
            pc_write_o  = 1'b0;
            ifid_hold_o = 1'b1;
            freeze_o    = 1'b1;
        end else if (w_loaduse) begin
            pc_write_o    = 1'b0;
            ifid_hold_o   = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i || jump_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    assign err_o   = r_err;
    assign state_o = rst_i ? RUN : r_state;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (ifid_hold_o && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (ifid_flush_o && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus multi-cycle sequences for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        memread, uses_rt, br, jmp, req, rdy;
    logic [4:0]  ex_rt, id_rs, id_rt;
    logic        pc_write, hold, flush, bubble, freeze, err;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    logic [4:0]  ctl;
    int          n_tests = 0;
    int          n_fail  = 0;

    typedef struct {
        string      name;
        logic       memread;
        logic [4:0] ex_rt, id_rs, id_rt;
        logic       uses_rt, br, jmp, req, rdy;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .idex_memread_i (memread),
        .idex_rt_i      (ex_rt),
        .ifid_rs_i      (id_rs),
        .ifid_rt_i      (id_rt),
        .ifid_uses_rt_i (uses_rt),
        .branch_taken_i (br),
        .jump_i         (jmp),
        .mem_req_i      (req),
        .mem_ready_i    (rdy),
        .pc_write_o     (pc_write),
        .ifid_hold_o    (hold),
        .ifid_flush_o   (flush),
        .idex_bubble_o  (bubble),
        .freeze_o       (freeze),
        .err_o          (err),
        .state_o        (state),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    // {pc_write, hold, flush, bubble, freeze}
    assign ctl = {pc_write, hold, flush, bubble, freeze};

    function automatic vec_t mk(input string n, input logic m, input logic [4:0] ert, irs, irt,
                                input logic u, b, j, rq, rd, input logic [4:0] e);
        vec_t v;
        v.name = n; v.memread = m; v.ex_rt = ert; v.id_rs = irs; v.id_rt = irt;
        v.uses_rt = u; v.br = b; v.jmp = j; v.req = rq; v.rdy = rd; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [4:0] ert, irs, irt,
                         input logic u, b, j, rq, rd);
        memread = m; ex_rt = ert; id_rs = irs; id_rt = irt;
        uses_rt = u; br = b; jmp = j; req = rq; rdy = rd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk("idle",          0, 0,  0,  0,  0, 0, 0, 0, 0, 5'b10000);
        vecs[1]  = mk("lu_rs",         1, 5,  5,  0,  0, 0, 0, 0, 0, 5'b01010);
        vecs[2]  = mk("lu_r0",         1, 0,  0,  0,  1, 0, 0, 0, 0, 5'b10000);
        vecs[3]  = mk("lu_rt",         1, 7,  3,  7,  1, 0, 0, 0, 0, 5'b01010);
        vecs[4]  = mk("rt_unused",     1, 7,  3,  7,  0, 0, 0, 0, 0, 5'b10000);
        vecs[5]  = mk("no_load",       0, 5,  5,  5,  1, 0, 0, 0, 0, 5'b10000);
        vecs[6]  = mk("branch",        0, 0,  0,  0,  0, 1, 0, 0, 0, 5'b10100);
        vecs[7]  = mk("jump",          0, 0,  0,  0,  0, 0, 1, 0, 0, 5'b10100);
        vecs[8]  = mk("lu_jump",       1, 9,  9,  0,  0, 0, 1, 0, 0, 5'b01010);
        vecs[9]  = mk("mem_ready_now", 0, 0,  0,  0,  0, 0, 0, 1, 1, 5'b10000);
        vecs[10] = mk("lu_r31",        1, 31, 31, 0,  0, 0, 0, 0, 0, 5'b01010);

        idle();
        rst = 1'b1;
        tick();
        chk("rst_ctl", 32'(ctl), 32'b00100);
        chk("rst_state", 32'(state), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].memread, vecs[i].ex_rt, vecs[i].id_rs, vecs[i].id_rt,
                  vecs[i].uses_rt, vecs[i].br, vecs[i].jmp, vecs[i].req, vecs[i].rdy);
            #3;
            chk(vecs[i].name, 32'(ctl), 32'(vecs[i].exp));
            chk({vecs[i].name, "_state"}, 32'(state), 0);
            tick();
        end

        drive(1, 5, 5, 0, 0, 1, 0, 0, 0);
        #3 chk("lu_br_no_flush", 32'(ctl), 32'b01010);
        tick();
        drive(0, 5, 5, 0, 0, 1, 0, 0, 0);
        #3 chk("br_after_bubble", 32'(ctl), 32'b10100);
        tick();

        for (int k = 0; k < 3; k++) begin
            if (k == 0) drive(1, 5, 5, 0, 0, 1, 0, 1, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            #3;
            chk($sformatf("wait3_ctl%0d", k), 32'(ctl), 32'b01001);
            chk($sformatf("wait3_state%0d", k), 32'(state), (k == 0) ? 0 : 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #3;
        chk("wait3_release_ctl", 32'(ctl), 32'b10000);
        chk("wait3_release_state", 32'(state), 1);
        tick();
        idle();
        #3 chk("wait3_back_run", 32'(state), 0);
        tick();

        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            #3;
            chk($sformatf("tmo_state%0d", k), 32'(state), (k == 0) ? 0 : 1);
            chk($sformatf("tmo_err%0d", k), 32'(err), 0);
            tick();
        end
        drive(1, 5, 5, 0, 0, 1, 0, 1, 1);
        #3;
        chk("err_state", 32'(state), 2);
        chk("err_flag", 32'(err), 1);
        chk("err_ctl", 32'(ctl), 32'b01001);
        tick();
        tick();
        chk("err_sticky", 32'(err), 1);
        chk("err_state_sticky", 32'(state), 2);
        idle();
        rst = 1'b1;
        #3;
        chk("err_rst_ctl", 32'(ctl), 32'b00100);
        chk("err_rst_state", 32'(state), 0);
        tick();
        rst = 1'b0;
        #3;
        chk("post_rst_state", 32'(state), 0);
        chk("post_rst_err", 32'(err), 0);
        chk("post_rst_ctl", 32'(ctl), 32'b10000);
        tick();

        drive(1, 5, 5, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        drive(1, 7, 3, 7, 1, 0, 0, 0, 0);
        tick();
        idle();
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        idle();
        #3;
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall", 32'(stall_cnt), 2);
        chk("perf_flush", 32'(flush_cnt), 1);
`else
        chk("perf_stall_off", 32'(stall_cnt), 0);
        chk("perf_flush_off", 32'(flush_cnt), 0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control sequencer for the 5-stage CPU. It produces the hold, flush and bubble controls consumed by the IF/ID register (HD/flush inputs), the PC write enable and the ID/EX bubble mux. It resolves three sources:

- load-use hazards;
- taken branches and jumps resolved in ID;
- multi-cycle data-memory waits, with a timeout watchdog.

## Interface

Clock and reset: one clock; reset is synchronous and active-high.

**Parameters**
- MEM_TIMEOUT, 16: max consecutive MEM wait cycles before error.
- CNT_W, 32: width of the performance counters.

**Ports**
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous active-high reset.
- idex_memread_i  in  1  instruction in EX is a load.
- idex_rt_i  in  5  load destination register in EX.
- ifid_rs_i  in  5  rs of instruction in ID.
- ifid_rt_i  in  5  rt of instruction in ID.
- ifid_uses_rt_i  in  1  ID instruction reads rt as a source.
- branch_taken_i  in  1  branch in ID resolved taken.
- jump_i  in  1  jump in ID.
- mem_req_i  in  1  MEM stage accessing data memory.
- mem_ready_i  in  1  data memory completes this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_hold_o  out  1  IF/ID keeps its value (HD).
- ifid_flush_o  out  1  IF/ID loads zero (nop).
- idex_bubble_o  out  1  ID/EX loads control zeros.
- freeze_o  out  1  EX/MEM and MEM/WB hold.
- err_o  out  1  sticky memory-timeout error.
- state_o  out  2  FSM state (debug).
- stall_cnt_o  out  CNT_W  stall cycle count.
- flush_cnt_o  out  CNT_W  flush cycle count.

## Operation

**FSM states:** RUN=0, MEM_WAIT=1, ERR=2.

**Control outputs** are combinational from state and inputs. IF/ID and PC sample them at the next edge.

**Signal definitions**
- memstall = mem_req_i & ~mem_ready_i.
- loaduse = idex_memread_i & (idex_rt_i != 0) & ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i))).

**Priority in RUN and MEM_WAIT:** memstall > loaduse > branch/jump.
- **memstall:** freeze_o=1, ifid_hold_o=1, pc_write_o=0, idex_bubble_o=0, ifid_flush_o=0.
- **loaduse:** ifid_hold_o=1, pc_write_o=0, idex_bubble_o=1, ifid_flush_o=0. A branch or jump in the same cycle is ignored; it is re-evaluated after the bubble.
- **branch_taken_i | jump_i:** ifid_flush_o=1, pc_write_o=1.
- **Otherwise:** pc_write_o=1, all other controls 0.

**Transitions**
- RUN → MEM_WAIT on memstall; wait counter is loaded to 1.
- MEM_WAIT:
  - mem_ready_i=1: next state RUN, counter cleared. Outputs that cycle follow the non-memstall rules.
  - Still waiting: counter increments.
  - Counter == MEM_TIMEOUT with memstall still high: next state ERR.
- ERR: err_o=1, freeze_o=1, ifid_hold_o=1, pc_write_o=0, flush and bubble 0. Leaves ERR only on rst_i.

**Reset** (rst_i high, has priority over everything):
- Next state RUN, wait counter 0, err_o 0, perf counters 0.
- During the reset cycle: pc_write_o=0, ifid_flush_o=1, all other controls 0, state_o=0.

**Wait counter width:** $clog2(MEM_TIMEOUT+1). It never wraps.

## Timing

- Zero-cycle control latency: a hazard detected in cycle N affects the registers at edge N+1.
- Load-use inserts exactly one bubble. After it, the load sits in MEM, so loaduse deasserts without FSM involvement.
- A memory wait of k cycles asserts freeze_o for exactly k cycles. The first cycle with mem_ready_i=1 releases it.
- ERR is entered at the edge after the MEM_TIMEOUT-th consecutive waiting cycle.
- err_o rises the cycle after that edge and stays high until reset.

## Configuration

Macro PIPE_CTRL_PERF_EN.
- **Defined:**
  - stall_cnt_o increments on every non-reset cycle with ifid_hold_o=1.
  - flush_cnt_o increments on every non-reset cycle with ifid_flush_o=1.
  - Both saturate at all-ones.
- **Undefined:** no counter registers; both ports are driven 0. The port list is identical in both builds.

## Structure

- **Package pipe_ctrl_pkg:**
  - state enum (RUN, MEM_WAIT, ERR), 2 bits;
  - REG_ADDR_W = 5;
  - ZERO_REG = 5'd0.
- **Sub-module load_use_detect:** purely combinational loaduse compare, instantiated once.

## Test plan

- **Load-use:** idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 → same cycle ifid_hold_o=1, pc_write_o=0, idex_bubble_o=1. With idex_rt_i=0 → no stall.
- **Load-use + branch:** loaduse with branch_taken_i=1 → no flush that cycle. Next cycle, branch_taken_i=1 alone → ifid_flush_o=1, pc_write_o=1.
- **3-cycle memory wait:** mem_req_i=1, mem_ready_i=0 for 3 cycles → freeze_o high exactly 3 cycles, state_o=1 for cycles 2–3, RUN after ready.
- **Timeout:** MEM_TIMEOUT=4, mem_ready_i held 0 → state ERR after the 4th wait cycle, err_o=1 stays high. rst_i=1 for one cycle → state 0, err_o 0; flush=1 and pc_write=0 during the reset cycle.
- **Perf (macro defined):** 2 load-use stalls + 1 jump → stall_cnt_o=2, flush_cnt_o=1. Macro undefined → both read 0.
